apb_master: RTL
===============

# apb_master

APB requester-side bridge that sits directly upstream of the two 256-byte APB slave memories and drives their shared APB bus. It accepts single read/write commands on a valid/ready interface and decodes `paddr[8]` into `psel1`/`psel2`. It sequences SETUP and ACCESS phases, waits on the selected slave's `pready` with a timeout, and returns read data and error status as a one-cycle response pulse.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS-phase cycles spent waiting for `pready` before aborting; legal range 1–255.
- `pclk`  in  1  single clock; all logic samples on the rising edge.
- `presetn`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  requester has a command.
- `cmd_ready`  out  1  bridge can accept a command; high only in IDLE and only while `presetn`=1.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  9  bit 8 selects the slave (0 = slave 1, 1 = slave 2); bits 7:0 are the byte address.
- `cmd_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  8  read data; 0 for writes and for timeouts.
- `rsp_err`  out  1  `pslverr` returned, or timeout.
- `rsp_timeout`  out  1  transaction aborted by the timeout.
- `err_cnt`  out  8  saturating count of `rsp_err` responses.
- `psel1`, `psel2`  out  1 each  APB selects.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `paddr`  out  9  APB address.
- `pwdata`  out  8  APB write data.
- `prdata1`, `prdata2`  in  8 each  slave read data.
- `pready1`, `pready2`  in  1 each  slave ready.
- `pslverr1`, `pslverr2`  in  1 each  slave error.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready` at an edge, latch write, addr and wdata; go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP** (exactly 1 cycle)
  - Drive `psel1 = ~addr[8]` and `psel2 = addr[8]`, with `penable`=0.
  - `paddr`, `pwrite` and `pwdata` carry the latched values.
  - Go to ACCESS.
- **ACCESS**
  - Same select and `penable`=1; APB signals are held stable.
  - `wait_cnt` starts at 0 and increments every ACCESS cycle.
  - Only the selected slave's `pready`/`pslverr`/`prdata` are observed; the other slave's signals are ignored.
  - **Completion** (selected `pready`=1 at an edge):
    - Go to IDLE.
    - Register `rsp_valid`=1 and `rsp_err` = selected `pslverr`.
    - Register `rsp_rdata` = selected `prdata` for reads, 0 for writes.
    - Set `rsp_timeout`=0.
  - **Timeout** (`pready`=0 at an edge and `wait_cnt == TIMEOUT_CYCLES-1`):
    - Go to IDLE.
    - Register `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1 and `rsp_rdata`=0.
- **err_cnt**: increments by 1 on every response with `rsp_err`=1 and saturates at 255. It is cleared only by reset.
- Outside SETUP and ACCESS, `psel1`, `psel2` and `penable` are 0. `paddr`, `pwrite` and `pwdata` hold their last values.
- While busy, `cmd_valid` is ignored (`cmd_ready`=0). The requester holds the command until it is accepted.
- **Reset**
  - Taking effect at any edge with `presetn`=0, including mid-transaction:
    - State goes to IDLE and all outputs become 0, including `err_cnt` and `paddr`/`pwdata`/`pwrite`.
    - The in-flight command is discarded.
  - No `rsp_valid` is produced for the aborted transaction.
  - `cmd_ready` stays 0 while `presetn`=0.

## Timing
- **Acceptance.** Acceptance at edge E0 gives SETUP in cycle 1 and ACCESS from cycle 2.
- **Slave behaviour.** The slave registers `pready` and read data.
  - Its first `pready` appears in cycle 3.
  - The bridge samples it at E3 and asserts `rsp_valid` in cycle 4, so a zero-wait transaction is 4 cycles from acceptance.
- **Wait states.** Each additional cycle in which the slave holds `pready` low adds 1 cycle.
- **Response cycle.** `rsp_valid` is high for exactly 1 cycle, which is an IDLE cycle. `cmd_ready`=1 in that same cycle, so back-to-back commands are accepted there; throughput is one transaction per 4 cycles.
- **Response stability.** `rsp_rdata`, `rsp_err` and `rsp_timeout` hold their values until the next response or reset.
- **Timeout latency.** A timeout produces `rsp_valid` exactly `TIMEOUT_CYCLES` ACCESS cycles after ACCESS entry. With the default, `rsp_valid` falls in cycle 2+16 = 18 after acceptance.
- **pready on the last allowed cycle.** If `pready` arrives on the same edge where the timeout would fire, completion wins (`rsp_timeout`=0).
- **Reset release.** `cmd_ready`=1 in the first cycle after the edge where `presetn` is sampled 1 following reset.

## Test plan
- Write `0x0A5` ← `0x3C`:
  - `psel1` high in cycles 1–3, `penable` high in cycles 2–3, `paddr`=`0x0A5`, `pwdata`=`0x3C`, `psel2`=0.
  - `rsp_valid` in cycle 4 with `rsp_err`=0 and `rsp_rdata`=0.
- Read `0x0A5` after the write → `rsp_rdata`=`0x3C`, `rsp_err`=0, latency 4 cycles.
- Write `0x1A5` ← `0x77` (only `psel2` asserted), then read `0x0A5` and `0x1A5` → `0x3C` and `0x77` respectively. Verifies that the two slaves are isolated.
- Hold `cmd_valid` high with 3 queued reads → each new command is accepted in the previous `rsp_valid` cycle, giving exactly 4 cycles per response.
- Stub slave with `pready` tied 0 and `TIMEOUT_CYCLES`=16:
  - `rsp_valid` in cycle 18 after acceptance with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - `err_cnt`=1.
  - Then `pslverr`=1 with `pready`=1 → `rsp_err`=1, `rsp_timeout`=0, `err_cnt`=2.
- Assert `presetn`=0 during ACCESS:
  - After that edge, `psel1`/`psel2`/`penable`/`err_cnt` are 0.
  - `rsp_valid` never pulses.
  - After release, `cmd_ready`=1 and a fresh write completes normally.

Source files
------------

// File: rtl/apb_master.sv
// apb_master
//   Requester-side APB bridge driving two 256-byte APB slaves on a shared bus.
//   Accepts one command at a time on a valid/ready handshake, decodes
//   cmd_addr[8] into psel1/psel2, runs SETUP then ACCESS, waits on the selected
//   slave's pready with a timeout, and reports the result as a one-cycle
//   response pulse.
//
// Ports
//   pclk, presetn           clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE, out of reset)
//   cmd_write/addr/wdata    command payload (addr[8] picks slave 2)
//   rsp_valid               one-cycle response strobe
//   rsp_rdata/err/timeout   response payload, held until the next response
//   err_cnt                 saturating count of error responses
//   psel1/psel2/penable/pwrite/paddr/pwdata   APB requester outputs
//   prdata*/pready*/pslverr*                  per-slave APB returns
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [8:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic [7:0] err_cnt,
  output logic       psel1,
  output logic       psel2,
  output logic       penable,
  output logic       pwrite,
  output logic [8:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata1,
  input  logic [7:0] prdata2,
  input  logic       pready1,
  input  logic       pready2,
  input  logic       pslverr1,
  input  logic       pslverr2
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state, w_next;
  logic       r_write;
  logic [8:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_wait_cnt;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic       r_rsp_timeout;
  logic [7:0] r_err_cnt;

  logic       w_accept;
  logic       w_pready;
  logic       w_pslverr;
  logic [7:0] w_prdata;
  logic       w_done;
  logic       w_to;

  // Only the addressed slave's return signals are ever looked at.
  assign w_pready  = r_addr[8] ? pready2  : pready1;
  assign w_pslverr = r_addr[8] ? pslverr2 : pslverr1;
  assign w_prdata  = r_addr[8] ? prdata2  : prdata1;

  assign cmd_ready = presetn & (r_state == S_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;

  always_ff @(posedge pclk) begin
    if (!presetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        // pready on the last allowed cycle counts as completion, not timeout
        w_to   = ~w_pready & (r_wait_cnt == LP_LAST_WAIT);
        w_done = w_pready | w_to;
        if (w_done) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wait_cnt    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      // Zero outside ACCESS, so it starts at 0 on ACCESS entry.
      if (r_state == S_ACCESS) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                     r_wait_cnt <= '0;
      if (w_done) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= w_to | w_pslverr;
        r_rsp_timeout <= w_to;
        r_rsp_rdata   <= (w_to | r_write) ? 8'h00 : w_prdata;
        if ((w_to | w_pslverr) && (r_err_cnt != 8'hFF))
          r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign psel1       = (r_state != S_IDLE) & ~r_addr[8];
  assign psel2       = (r_state != S_IDLE) &  r_addr[8];
  assign penable     = (r_state == S_ACCESS);
  assign pwrite      = r_write;
  assign paddr       = r_addr;
  assign pwdata      = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign err_cnt     = r_err_cnt;

endmodule
